// File: rtl/univ_shift_register.sv
// Universal shift register: hold/load/shift/rotate/asr, plus a
// multi-cycle burst shift with registered busy/done handshake.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mode[2:0]         000 hold 001 load 010 shl 011 shr
//                     100 rotl 101 rotr 110 asr 111 hold
//   start, shift_amt  burst request and its length in steps
//   serial_in_l/_r    fill bits entering MSB (shr) / LSB (shl)
//   parallel_in       load data
//   parallel_out      register contents
//   serial_out_l/_r   MSB / LSB of parallel_out
//   busy, done        burst in progress / request complete pulse
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_amt,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       burst_mode_q;
  logic [2:0]       step_mode;
  logic             busy_q;
  logic             done_q;
  logic             is_shift;

  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = q;
    unique case (op)
      M_SHL:   r = {q[WIDTH-2:0], sr};
      M_SHR:   r = {sl, q[WIDTH-1:1]};
      M_ROTL:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROTR:  r = {q[0], q[WIDTH-1:1]};
      M_ASR:   r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

  // During a burst the latched mode drives the step, not the live input.
  always_comb begin
    step_mode = (state_q == BURST) ? burst_mode_q : mode;
    step_d    = step_op(step_mode, data_q, serial_in_l, serial_in_r);
    is_shift  = (mode >= M_SHL) && (mode <= M_ASR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      burst_mode_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (is_shift && (shift_amt != '0)) begin
              burst_mode_q <= mode;
              cnt_q        <= shift_amt;
              busy_q       <= 1'b1;
              state_q      <= BURST;
            end else begin
              // Zero-length request: acknowledge only.
              done_q <= 1'b1;
            end
          end else if (mode == M_LOAD) begin
            data_q <= parallel_in;
          end else if (is_shift) begin
            data_q <= step_d;
          end
        end
        BURST: begin
          data_q <= step_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign parallel_out = data_q;
  assign serial_out_l = data_q[WIDTH-1];
  assign serial_out_r = data_q[0];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed bench for univ_shift_register (WIDTH=8, CNT_W=4).
module tb_univ_shift_register;

  logic       clk;
  logic       reset;
  logic [2:0] mode;
  logic       start;
  logic [3:0] shift_amt;
  logic       serial_in_l;
  logic       serial_in_r;
  logic [7:0] parallel_in;
  logic [7:0] parallel_out;
  logic       serial_out_l;
  logic       serial_out_r;
  logic       busy;
  logic       done;

  int n_run;
  int n_fail;

  univ_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .start        (start),
    .shift_amt    (shift_amt),
    .serial_in_l  (serial_in_l),
    .serial_in_r  (serial_in_r),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .serial_out_l (serial_out_l),
    .serial_out_r (serial_out_r),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'b001;
    parallel_in = v;
    tick();
    mode = 3'b000;
  endtask

  task automatic one_op(input string tag, input logic [2:0] op,
                        input logic sl, input logic sr,
                        input logic [7:0] exp);
    load(8'hA5);
    mode = op;
    serial_in_l = sl;
    serial_in_r = sr;
    tick();
    mode = 3'b000;
    chk(tag, parallel_out, exp);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    reset = 1'b1;
    mode = 3'b000;
    start = 1'b0;
    shift_amt = '0;
    serial_in_l = 1'b0;
    serial_in_r = 1'b0;
    parallel_in = '0;
    tick();
    tick();
    chk("rst_q", parallel_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;

    load(8'hA5);
    chk("load_a5", parallel_out, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", parallel_out, 8'hA5);
    end
    chk("sout_l", serial_out_l, 1'b1);
    chk("sout_r", serial_out_r, 1'b1);

    one_op("rotl", 3'b100, 1'b0, 1'b0, 8'h4B);
    one_op("rotr", 3'b101, 1'b0, 1'b0, 8'hD2);
    one_op("asr",  3'b110, 1'b0, 1'b0, 8'hD2);
    one_op("shr",  3'b011, 1'b0, 1'b0, 8'h52);
    one_op("shl",  3'b010, 1'b0, 1'b1, 8'h4B);
    one_op("m111", 3'b111, 1'b1, 1'b1, 8'hA5);

    // Reset in the middle of free-running rotation.
    mode = 3'b100;
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_q", parallel_out, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    chk("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    mode = 3'b000;

    // Burst rotl x3 from 81.
    load(8'h81);
    start = 1'b1;
    mode = 3'b100;
    shift_amt = 4'd3;
    tick();
    start = 1'b0;
    mode = 3'b000;
    chk("b_acc_q", parallel_out, 8'h81);
    chk("b_acc_busy", busy, 1'b1);
    chk("b_acc_done", done, 1'b0);
    tick();
    chk("b1_q", parallel_out, 8'h03);
    chk("b1_busy", busy, 1'b1);
    tick();
    chk("b2_q", parallel_out, 8'h06);
    chk("b2_busy", busy, 1'b1);
    chk("b2_done", done, 1'b0);
    tick();
    chk("b3_q", parallel_out, 8'h0C);
    chk("b3_busy", busy, 1'b0);
    chk("b3_done", done, 1'b1);

    // Start accepted in the done cycle: rotr x1.
    start = 1'b1;
    mode = 3'b101;
    shift_amt = 4'd1;
    tick();
    start = 1'b0;
    mode = 3'b000;
    chk("re_busy", busy, 1'b1);
    chk("re_done", done, 1'b0);
    tick();
    chk("re_q", parallel_out, 8'h06);
    chk("re_done2", done, 1'b1);
    chk("re_busy2", busy, 1'b0);
    tick();
    chk("re_done3", done, 1'b0);

    // Zero-length requests.
    start = 1'b1;
    mode = 3'b010;
    shift_amt = 4'd0;
    tick();
    start = 1'b0;
    chk("z0_done", done, 1'b1);
    chk("z0_busy", busy, 1'b0);
    chk("z0_q", parallel_out, 8'h06);
    mode = 3'b000;
    tick();
    chk("z0_done2", done, 1'b0);
    start = 1'b1;
    mode = 3'b001;
    shift_amt = 4'd3;
    parallel_in = 8'hFF;
    tick();
    start = 1'b0;
    mode = 3'b000;
    chk("zl_done", done, 1'b1);
    chk("zl_q", parallel_out, 8'h06);
    tick();

    // Start held high during a burst is ignored.
    start = 1'b1;
    mode = 3'b011;
    shift_amt = 4'd2;
    serial_in_l = 1'b1;
    tick();
    mode = 3'b100;
    shift_amt = 4'd5;
    parallel_in = 8'h00;
    tick();
    chk("ib1_q", parallel_out, 8'h83);
    chk("ib1_done", done, 1'b0);
    start = 1'b0;
    mode = 3'b000;
    tick();
    chk("ib2_q", parallel_out, 8'hC1);
    chk("ib2_done", done, 1'b1);
    chk("ib2_sl", serial_out_l, 1'b1);
    tick();
    chk("ib3_done", done, 1'b0);
    chk("ib3_busy", busy, 1'b0);
    chk("ib3_q", parallel_out, 8'hC1);
    serial_in_l = 1'b0;

    // shift_amt > WIDTH: rotl x9 == rotl x1.
    load(8'h81);
    start = 1'b1;
    mode = 3'b100;
    shift_amt = 4'd9;
    tick();
    start = 1'b0;
    mode = 3'b000;
    begin
      int cyc;
      cyc = 0;
      while (!done && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("long_cyc", cyc, 9);
    end
    chk("long_q", parallel_out, 8'h03);

    // Reset in the 2nd cycle of a 5-step burst.
    tick();
    load(8'h0F);
    start = 1'b1;
    mode = 3'b100;
    shift_amt = 4'd5;
    tick();
    start = 1'b0;
    mode = 3'b000;
    tick();
    chk("ab_step", parallel_out, 8'h1E);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_q", parallel_out, 8'h00);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("ab_quiet", seen, 0);
    end
    chk("ab_q2", parallel_out, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
